// File: rtl/usb_uart_arb_pkg.sv
// rtl/usb_uart_arb_pkg.sv - shared types and constants for the usb_uart port arbiter
package usb_uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        CAP  = 2'd3
    } arb_state_t;

    localparam int REQ_TX0 = 0;
    localparam int REQ_TX1 = 1;
    localparam int REQ_RX  = 2;

    localparam int TMO_W = 16;

endpackage

// File: rtl/usb_uart_arbiter_rr_arb3.sv
// rtl/usb_uart_arbiter_rr_arb3.sv - three-way round-robin grant with registered priority pointer
module rr_arb3
    import usb_uart_arb_pkg::*;
(
    input  logic       clk_48mhz,
    input  logic       resetn,
    input  logic [2:0] req,
    input  logic       grant_take,
    output logic [2:0] grant
);

    logic [1:0] r_ptr;
    logic [1:0] w_idx;
    logic [1:0] w_win;
    logic       w_found;

    // Scan the slots starting at the pointer; the first active one wins.
    always_comb begin
        grant   = '0;
        w_idx   = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            w_idx = 2'((3'(r_ptr) + 3'(k)) % 3'd3);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        if (w_found) begin
            grant[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (!resetn) begin
            r_ptr <= 2'(REQ_TX0);
        end else if (grant_take && w_found) begin
            r_ptr <= (w_win == 2'(REQ_RX)) ? 2'(REQ_TX0) : w_win + 2'd1;
        end
    end

endmodule

// File: rtl/usb_uart_arbiter.sv
// rtl/usb_uart_arbiter.sv - shares the usb_uart byte port between two tx clients and one rx consumer
module usb_uart_arbiter
    import usb_uart_arb_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 48000
) (
    input  logic       clk_48mhz,
    input  logic       resetn,
    input  logic [7:0] tx0_data,
    input  logic       tx0_valid,
    output logic       tx0_ready,
    input  logic [7:0] tx1_data,
    input  logic       tx1_valid,
    output logic       tx1_ready,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       uart_we,
    output logic       uart_re,
    output logic [7:0] uart_di,
    input  logic [7:0] uart_do,
    input  logic       uart_wait,
    output logic       busy,
    output logic       stall
);

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(WAIT_TIMEOUT);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_we;
    logic             r_re;
    logic [7:0]       r_di;
    logic             r_tx0_ready;
    logic             r_tx1_ready;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_stall;
    logic [TMO_W-1:0] r_wait_cnt;

    logic             w_we_nxt;
    logic             w_re_nxt;
    logic [7:0]       w_di_nxt;
    logic             w_tx0_ready_nxt;
    logic             w_tx1_ready_nxt;
    logic [7:0]       w_rx_data_nxt;
    logic             w_rx_valid_nxt;
    logic [2:0]       w_req;
    logic [2:0]       w_grant;
    logic             w_take;
    logic             w_done;
    logic             w_counting;

    // A read is only requested while the one-byte receive buffer is empty.
    assign w_req[REQ_TX0] = tx0_valid;
    assign w_req[REQ_TX1] = tx1_valid;
    assign w_req[REQ_RX]  = rx_en && !r_rx_valid;

    assign w_take     = (r_state == IDLE) && (|w_req);
    assign w_done     = (r_we || r_re) && !uart_wait;
    assign w_counting = ((r_state == WR) || (r_state == RD)) && uart_wait;

    rr_arb3 u_rr_arb3 (
        .clk_48mhz  (clk_48mhz),
        .resetn     (resetn),
        .req        (w_req),
        .grant_take (w_take),
        .grant      (w_grant)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_we_nxt        = r_we;
        w_re_nxt        = r_re;
        w_di_nxt        = r_di;
        w_tx0_ready_nxt = 1'b0;
        w_tx1_ready_nxt = 1'b0;
        w_rx_data_nxt   = r_rx_data;
        w_rx_valid_nxt  = r_rx_valid && !rx_ready;
        case (r_state)
            IDLE: begin
                if (w_grant[REQ_TX0]) begin
                    w_di_nxt        = tx0_data;
                    w_we_nxt        = 1'b1;
                    w_tx0_ready_nxt = 1'b1;
                    w_state_nxt     = WR;
                end else if (w_grant[REQ_TX1]) begin
                    w_di_nxt        = tx1_data;
                    w_we_nxt        = 1'b1;
                    w_tx1_ready_nxt = 1'b1;
                    w_state_nxt     = WR;
                end else if (w_grant[REQ_RX]) begin
                    w_re_nxt    = 1'b1;
                    w_state_nxt = RD;
                end
            end
            WR: begin
                if (w_done) begin
                    w_we_nxt    = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            RD: begin
                if (w_done) begin
                    w_re_nxt    = 1'b0;
                    w_state_nxt = CAP;
                end
            end
            CAP: begin
                w_rx_data_nxt  = uart_do;
                w_rx_valid_nxt = 1'b1;
                w_state_nxt    = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_di        <= '0;
            r_tx0_ready <= 1'b0;
            r_tx1_ready <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_we        <= w_we_nxt;
            r_re        <= w_re_nxt;
            r_di        <= w_di_nxt;
            r_tx0_ready <= w_tx0_ready_nxt;
            r_tx1_ready <= w_tx1_ready_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
        end
    end

    // Stall is raised on the edge the wait counter reaches the limit and is never cleared by traffic.
    always_ff @(posedge clk_48mhz) begin
        if (!resetn) begin
            r_wait_cnt <= '0;
            r_stall    <= 1'b0;
        end else if (w_counting) begin
            if (r_wait_cnt != TMO_LIM) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (r_wait_cnt == TMO_LIM - 1'b1) begin
                r_stall <= 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign uart_we   = r_we;
    assign uart_re   = r_re;
    assign uart_di   = r_di;
    assign tx0_ready = r_tx0_ready;
    assign tx1_ready = r_tx1_ready;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign busy      = (r_state != IDLE);
    assign stall     = r_stall;

endmodule
